// File: rtl/conveng_pkg.sv
// Shared definitions for the line-buffer scheduler: FSM state encoding and
// the ring-pointer width helper.
package conveng_pkg;

   // Scheduler frame phases.
   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StSteady,
      StDrain
   } state_e;

   localparam int unsigned NM_DEFAULT = 4;

   // Width of an index into NM buffers; never less than one bit.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned PTR_W = ptr_width(NM_DEFAULT);

endpackage

// File: rtl/ring_ptr.sv
// Modulo-N pointer with synchronous clear and single-step increment.
module ring_ptr
   import conveng_pkg::*;
#(
   parameter int unsigned N = NM_DEFAULT,
   parameter int unsigned W = PTR_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_value
);

   logic [W-1:0] r_ptr;

   // Advance with wrap at N-1; clear has priority over increment.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_ptr <= '0;
      end else if (i_clr) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= (r_ptr == W'(N - 1)) ? '0 : r_ptr + 1'b1;
      end
   end

   assign o_value = r_ptr;

endmodule

// File: rtl/line_buf_sched.sv
// Line-buffer scheduler: tracks NM line buffers as a ring, hands the writer a
// free buffer and presents K = NM-1 consecutive lines as a window.
// Optional build macro: LINE_BUF_SCHED_PERF_EN enables the stall/starve counters.
module line_buf_sched
   import conveng_pkg::*;
#(
   parameter int unsigned XB = 10,
   parameter int unsigned YB = 10,
   parameter int unsigned NM = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [XB-1:0]         i_cfg_width,
   input  logic [YB-1:0]         i_cfg_height,
   input  logic                  i_start,
   input  logic                  i_wr_line_done,
   input  logic                  i_rd_line_done,
   output logic [NM-1:0]         o_wr_sel,
   output logic                  o_wr_ready,
   output logic                  o_win_valid,
   output logic [$clog2(NM)-1:0] o_win_base,
   output logic [NM-1:0]         o_win_mask,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic                  o_err,
   output logic [15:0]           o_perf_wr_stall,
   output logic [15:0]           o_perf_rd_starve
);

   localparam int unsigned K  = NM - 1;
   localparam int unsigned PW = ptr_width(NM);
   localparam int unsigned OW = $clog2(NM + 1);
   localparam logic [NM-1:0] KMASK = {1'b0, {K{1'b1}}};

   state_e        r_state, w_state_d;
   logic [OW-1:0] r_occ, w_occ_d;
   logic [YB-1:0] r_rows, w_rows_d;
   logic [YB-1:0] r_wins, w_wins_d;
   logic [YB-1:0] r_cfg_h, w_cfg_h_d;
   logic [YB-1:0] w_win_lim;
   logic          r_wr_ready, w_wr_ready_d;
   logic          r_win_valid, w_win_valid_d;
   logic          r_busy, r_frame_done, r_err;
   logic          w_done;
   logic          w_start_idle, w_cfg_ok, w_start_ok, w_start_bad;
   logic          w_wr_acc, w_rd_acc, w_wr_drop, w_rd_drop;
   logic [PW-1:0] w_wr_ptr, w_rd_ptr;

   // A zero-width line can never be written, so it is rejected like a short frame.
   assign w_start_idle = i_start && (r_state == StIdle);
   assign w_cfg_ok     = (i_cfg_height >= YB'(K)) && (|i_cfg_width);
   assign w_start_ok   = w_start_idle && w_cfg_ok;
   assign w_start_bad  = w_start_idle && !w_cfg_ok;
   assign w_wr_acc     = i_wr_line_done && r_wr_ready;
   assign w_rd_acc     = i_rd_line_done && r_win_valid;
   assign w_wr_drop    = i_wr_line_done && !r_wr_ready;
   assign w_rd_drop    = i_rd_line_done && !r_win_valid;
   assign w_win_lim    = r_cfg_h - YB'(K - 1);

   ring_ptr #(
      .N (NM),
      .W (PW)
   ) u_wr_ptr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (w_wr_acc),
      .i_clr   (w_start_ok),
      .o_value (w_wr_ptr)
   );

   ring_ptr #(
      .N (NM),
      .W (PW)
   ) u_rd_ptr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (w_rd_acc),
      .i_clr   (w_start_ok),
      .o_value (w_rd_ptr)
   );

   // Next-state for counters, FSM and the registered ready/valid flags.
   always_comb begin
      w_state_d = r_state;
      w_done    = 1'b0;
      w_cfg_h_d = w_start_ok ? i_cfg_height : r_cfg_h;
      w_rows_d  = w_start_ok ? '0 : r_rows + YB'(w_wr_acc);
      w_wins_d  = w_start_ok ? '0 : r_wins + YB'(w_rd_acc);
      w_occ_d   = w_start_ok ? '0 : r_occ + OW'(w_wr_acc) - OW'(w_rd_acc);
      unique case (r_state)
         StIdle:   if (w_start_ok) w_state_d = StFill;
         StFill:   if (w_occ_d >= OW'(K)) w_state_d = StSteady;
         StSteady: if (w_rows_d == r_cfg_h) w_state_d = StDrain;
         StDrain: begin
            if (w_wins_d == w_win_lim) begin
               w_state_d = StIdle;
               w_done    = 1'b1;
               w_occ_d   = '0;
            end
         end
         default:  w_state_d = StIdle;
      endcase
      w_wr_ready_d  = ((w_state_d == StFill) || (w_state_d == StSteady)) &&
                      (w_occ_d < OW'(NM)) && (w_rows_d < w_cfg_h_d);
      // Window limit cannot underflow during a frame: height >= K is enforced at start.
      w_win_valid_d = (w_occ_d >= OW'(K)) && (w_wins_d < (w_cfg_h_d - YB'(K - 1)));
   end

   // Scheduler state and registered status outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state      <= StIdle;
         r_occ        <= '0;
         r_rows       <= '0;
         r_wins       <= '0;
         r_cfg_h      <= '0;
         r_wr_ready   <= 1'b0;
         r_win_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_occ        <= w_occ_d;
         r_rows       <= w_rows_d;
         r_wins       <= w_wins_d;
         r_cfg_h      <= w_cfg_h_d;
         r_wr_ready   <= w_wr_ready_d;
         r_win_valid  <= w_win_valid_d;
         r_busy       <= (w_state_d != StIdle);
         r_frame_done <= w_done;
         r_err        <= (w_start_ok ? 1'b0 : r_err) | w_start_bad | w_wr_drop | w_rd_drop;
      end
   end

   // Window mask is KMASK rotated left by rd_ptr (done as a right shift of a doubled copy).
   assign o_wr_sel     = r_wr_ready ? (NM'(1) << w_wr_ptr) : '0;
   assign o_win_mask   = r_win_valid ? NM'({KMASK, KMASK} >> (NM - int'(w_rd_ptr))) : '0;
   assign o_win_base   = w_rd_ptr;
   assign o_wr_ready   = r_wr_ready;
   assign o_win_valid  = r_win_valid;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;
   assign o_err        = r_err;

`ifdef LINE_BUF_SCHED_PERF_EN
   logic [15:0] r_perf_ws, r_perf_rs;

   // Saturating stall/starve counters, cleared by an accepted start.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_perf_ws <= '0;
         r_perf_rs <= '0;
      end else if (w_start_ok) begin
         r_perf_ws <= '0;
         r_perf_rs <= '0;
      end else begin
         if (r_busy && (r_occ == OW'(NM)) && (r_perf_ws != 16'hFFFF)) begin
            r_perf_ws <= r_perf_ws + 16'd1;
         end
         if ((r_state == StSteady) && !r_win_valid && (r_perf_rs != 16'hFFFF)) begin
            r_perf_rs <= r_perf_rs + 16'd1;
         end
      end
   end

   assign o_perf_wr_stall  = r_perf_ws;
   assign o_perf_rd_starve = r_perf_rs;
`else
   assign o_perf_wr_stall  = 16'd0;
   assign o_perf_rd_starve = 16'd0;
`endif

endmodule

// File: tb/tb_line_buf_sched.sv
// Scoreboard bench for line_buf_sched (NM=4, K=3).
module tb_line_buf_sched;

   localparam int unsigned XB = 10;
   localparam int unsigned YB = 10;
   localparam int unsigned NM = 4;
`ifdef LINE_BUF_SCHED_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] base;
      logic [3:0] mask;
   } win_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [XB-1:0] cfg_w = '0;
   logic [YB-1:0] cfg_h = '0;
   logic          start = 1'b0;
   logic          wr = 1'b0;
   logic          man_rd = 1'b0;
   logic          auto_rd = 1'b0;
   logic          rd;
   logic [NM-1:0] wr_sel, win_mask;
   logic [1:0]    win_base;
   logic          wr_ready, win_valid, busy, frame_done, err;
   logic [15:0]   perf_ws, perf_rs;

   int   n_chk = 0;
   int   n_pass = 0;
   int   win_cnt = 0;
   win_t win_q[$];
   int   fd_q[$];

   always #5 clk = ~clk;

   assign rd = (auto_rd && win_valid) || man_rd;

   line_buf_sched #(
      .XB (XB),
      .YB (YB),
      .NM (NM)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_cfg_width      (cfg_w),
      .i_cfg_height     (cfg_h),
      .i_start          (start),
      .i_wr_line_done   (wr),
      .i_rd_line_done   (rd),
      .o_wr_sel         (wr_sel),
      .o_wr_ready       (wr_ready),
      .o_win_valid      (win_valid),
      .o_win_base       (win_base),
      .o_win_mask       (win_mask),
      .o_busy           (busy),
      .o_frame_done     (frame_done),
      .o_err            (err),
      .o_perf_wr_stall  (perf_ws),
      .o_perf_rd_starve (perf_rs)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_win(input logic [1:0] b, input logic [3:0] m);
      win_t w;
      w.base = b;
      w.mask = m;
      win_q.push_back(w);
   endtask

   task automatic push_std3();
      push_win(2'd0, 4'b0111);
      push_win(2'd1, 4'b1110);
      push_win(2'd2, 4'b1101);
   endtask

   task automatic start_frame(input int w, input int h, input int nwin);
      cfg_w = XB'(w);
      cfg_h = YB'(h);
      if (nwin > 0) fd_q.push_back(nwin);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic write1();
      int t = 0;
      while (!wr_ready && t < 200) begin
         tick(1);
         t++;
      end
      check("wr_ready_wait", 32'(wr_ready), 1);
      wr = 1'b1;
      tick(1);
      wr = 1'b0;
   endtask

   task automatic wait_frame();
      int t = 0;
      while (fd_q.size() != 0 && t < 500) begin
         tick(1);
         t++;
      end
      check("frame_done_wait", 32'(fd_q.size()), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_wr_sel"}, 32'(wr_sel), 0);
      check({tag, "_wr_ready"}, 32'(wr_ready), 0);
      check({tag, "_win_valid"}, 32'(win_valid), 0);
      check({tag, "_win_mask"}, 32'(win_mask), 0);
      check({tag, "_win_base"}, 32'(win_base), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_perf_ws"}, 32'(perf_ws), 0);
      check({tag, "_perf_rs"}, 32'(perf_rs), 0);
   endtask

   // Monitor: every consumed window and every frame_done is matched against the scoreboard.
   always @(negedge clk) begin
      if (win_valid && rd) begin
         if (win_q.size() == 0) begin
            n_chk++;
            $display("FAIL win_extra: got base %0d mask %b want no window", win_base, win_mask);
         end else begin
            win_t w;
            w = win_q.pop_front();
            check("win_base", 32'(win_base), 32'(w.base));
            check("win_mask", 32'(win_mask), 32'(w.mask));
         end
         win_cnt++;
      end
      if (frame_done) begin
         if (fd_q.size() == 0) begin
            n_chk++;
            $display("FAIL frame_done_extra: got pulse want none");
         end else begin
            check("frame_windows", 32'(win_cnt), 32'(fd_q.pop_front()));
         end
         win_cnt = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick(3);
      check_reset("rst");
      rst = 1'b1;
      tick(1);

      // Height below K is rejected and stays idle.
      start_frame(10, 2, 0);
      check("short_err", 32'(err), 1);
      check("short_busy", 32'(busy), 0);
      check("short_ready", 32'(wr_ready), 0);

      // Spaced writes, reads on demand; cfg change mid-frame must not matter.
      push_std3();
      start_frame(10, 5, 3);
      check("a_err_clr", 32'(err), 0);
      check("a_busy", 32'(busy), 1);
      check("a_wr_sel0", 32'(wr_sel), 32'b0001);
      cfg_h = YB'(1);
      auto_rd = 1'b1;
      for (int i = 0; i < 5; i++) begin
         write1();
         if (i < 4) tick(11);
      end
      wait_frame();
      auto_rd = 1'b0;
      check("a_perf_rs", 32'(perf_rs), PERF ? 22 : 0);
      check("a_perf_ws", 32'(perf_ws), 0);
      check("a_busy_end", 32'(busy), 0);

      // Fill all four buffers with no reads.
      start_frame(10, 5, 3);
      check("b_perf_ws_clr", 32'(perf_ws), 0);
      check("b_perf_rs_clr", 32'(perf_rs), 0);
      for (int i = 0; i < 4; i++) write1();
      check("b_full_ready", 32'(wr_ready), 0);
      check("b_full_sel", 32'(wr_sel), 0);
      check("b_full_valid", 32'(win_valid), 1);
      check("b_full_mask", 32'(win_mask), 32'b0111);
      check("b_full_err", 32'(err), 0);
      tick(5);
      check("b_perf_ws", 32'(perf_ws), PERF ? 5 : 0);
      wr = 1'b1;
      tick(1);
      wr = 1'b0;
      check("b_drop_err", 32'(err), 1);
      push_std3();
      auto_rd = 1'b1;
      write1();
      wait_frame();
      auto_rd = 1'b0;
      check("b_err_sticky", 32'(err), 1);

      // Simultaneous write and read in STEADY, plus ignored start while busy.
      start_frame(10, 6, 4);
      check("c_err_clr", 32'(err), 0);
      for (int i = 0; i < 3; i++) write1();
      check("c_sel3", 32'(wr_sel), 32'b1000);
      check("c_base0", 32'(win_base), 0);
      push_std3();
      push_win(2'd3, 4'b1011);
      wr = 1'b1;
      man_rd = 1'b1;
      tick(1);
      wr = 1'b0;
      man_rd = 1'b0;
      check("c_both_sel", 32'(wr_sel), 32'b0001);
      check("c_both_base", 32'(win_base), 1);
      check("c_both_mask", 32'(win_mask), 32'b1110);
      check("c_both_valid", 32'(win_valid), 1);
      cfg_h = YB'(2);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("c_busy_start_err", 32'(err), 0);
      check("c_busy_start_busy", 32'(busy), 1);
      auto_rd = 1'b1;
      write1();
      write1();
      wait_frame();
      auto_rd = 1'b0;

      // Reset mid-frame abandons it; then a clean frame runs.
      start_frame(10, 5, 0);
      write1();
      write1();
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      check_reset("midrst");
      tick(3);
      push_std3();
      start_frame(10, 5, 3);
      auto_rd = 1'b1;
      for (int i = 0; i < 5; i++) write1();
      wait_frame();
      auto_rd = 1'b0;

      // Height exactly K: one window, writer closes after K lines.
      push_win(2'd0, 4'b0111);
      start_frame(10, 3, 1);
      for (int i = 0; i < 3; i++) write1();
      check("f_ready", 32'(wr_ready), 0);
      check("f_valid", 32'(win_valid), 1);
      check("f_busy", 32'(busy), 1);
      auto_rd = 1'b1;
      wait_frame();
      auto_rd = 1'b0;
      check("f_err_clean", 32'(err), 0);
      man_rd = 1'b1;
      tick(1);
      man_rd = 1'b0;
      check("f_rd_drop_err", 32'(err), 1);

      tick(2);
      check("win_q_empty", 32'(win_q.size()), 0);
      check("fd_q_empty", 32'(fd_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/line_buf_sched.md
LINE_BUF_SCHED -- requirements
Module: line_buf_sched

Interface
REQ-001 The block SHALL have parameter XB, default 10, frame width counter bits.
REQ-002 The block SHALL have parameter YB, default 10, frame height counter bits.
REQ-003 The block SHALL have parameter NM, default 4, number of line buffers; the window depth is K = NM-1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cfg_width  input  XB  pixels per line; sampled on start.
REQ-007 cfg_height  input  YB  lines per frame; sampled on start.
REQ-008 start  input  1  single-cycle frame start request.
REQ-009 wr_line_done  input  1  input side finished writing one complete line into the wr_sel buffer.
REQ-010 rd_line_done  input  1  consumer finished one output row using the current window.
REQ-011 wr_sel  output  NM  one-hot buffer currently open for writing.
REQ-012 wr_ready  output  1  a free buffer is available for writing.
REQ-013 win_valid  output  1  K consecutive lines are buffered and a window is pending.
REQ-014 win_base  output  clog2(NM)  index of the oldest line in the window.
REQ-015 win_mask  output  NM  bits set for the K buffers in the window; zero when win_valid is 0.
REQ-016 busy  output  1  frame in progress.
REQ-017 frame_done  output  1  one-cycle pulse after the last window is consumed.
REQ-018 err  output  1  sticky protocol/config error flag; cleared by start or reset.
REQ-019 perf_wr_stall, perf_rd_starve  output  16 each  performance counters (see Configuration).

Function
REQ-020 The FSM SHALL have states IDLE, FILL, STEADY, DRAIN; IDLE->FILL on start when cfg_height >= K, else err=1 and remain in IDLE.
REQ-021 start while busy SHALL be ignored.
REQ-022 Counters: occ (0..NM lines held), wr_ptr, rd_ptr (mod NM), rows_in (YB bits), wins_out (YB bits); all cleared on an accepted start.
REQ-023 An accepted wr_line_done (wr_ready=1) SHALL do occ+1, wr_ptr+1 mod NM, rows_in+1 on the next edge.
REQ-024 An accepted rd_line_done (win_valid=1) SHALL do occ-1, rd_ptr+1 mod NM, wins_out+1 on the next edge.
REQ-025 Simultaneous accepted write and read SHALL leave occ unchanged and advance both pointers.
REQ-026 wr_line_done with wr_ready=0, or rd_line_done with win_valid=0, SHALL be dropped and set err.
REQ-027 wr_ready SHALL be 1 exactly when state is FILL or STEADY, occ < NM and rows_in < cfg_height.
REQ-028 win_valid SHALL be 1 exactly when occ >= K and wins_out < cfg_height-K+1; registered, visible the cycle after the causing event.
REQ-029 FILL->STEADY when occ reaches K; STEADY->DRAIN when rows_in reaches cfg_height; DRAIN->IDLE when wins_out reaches cfg_height-K+1, with frame_done pulsed and occ cleared in that transition.
REQ-030 wr_sel SHALL equal onehot(wr_ptr) when wr_ready=1, else 0; win_mask = onehot(rd_ptr+i mod NM), i=0..K-1, when win_valid=1.
REQ-031 cfg values SHALL be held in internal registers for the whole frame; mid-frame cfg changes have no effect.

Reset
REQ-032 On rst=0 at a clock edge: state IDLE, occ/pointers/row counters 0, wr_sel 0, wr_ready 0, win_valid 0, win_mask 0, win_base 0, busy 0, frame_done 0, err 0, perf counters 0.
REQ-033 Reset mid-frame SHALL abandon the frame without a frame_done pulse.

Configuration
REQ-034 With macro LINE_BUF_SCHED_PERF_EN defined: perf_wr_stall counts busy cycles with occ=NM, perf_rd_starve counts STEADY cycles with win_valid=0; both saturate at 16'hFFFF and clear on accepted start.
REQ-035 Without LINE_BUF_SCHED_PERF_EN the ports SHALL exist and be driven constant 0, with no counter logic.

Structure
REQ-036 The shared package conveng_pkg SHALL hold the FSM state enum and the pointer-width constant derived from NM.
REQ-037 The modulo-NM pointer SHALL be a sub-module ring_ptr (inc, clear, value), instantiated for wr_ptr and rd_ptr.

Verification (NM=4, K=3)
REQ-038 cfg 10x5, start, 5 write pulses spaced 12 cycles, reads on win_valid -> win_base 0,1,2; win_mask 0111,1110,1101; frame_done once after 3rd read.
REQ-039 4 writes, no reads -> occ=4, wr_ready=0, 5th wr_line_done sets err, perf_wr_stall increments each stalled cycle.
REQ-040 In STEADY with occ=3, wr_line_done and rd_line_done same cycle -> occ stays 3, wr_ptr and rd_ptr both advance by 1.
REQ-041 start with cfg_height=2 -> err=1, state IDLE, busy=0, wr_ready=0.
REQ-042 rst low for one cycle after 2nd write -> all outputs at reset values next cycle, no frame_done; fresh start runs a full frame correctly.
